// File: rtl/seq_mul_param_if.sv
// seq_mul_param_if
//   Handshake/data bundle for the iterative multiplier.
//   master : requester side (drives start, abort, signed_mode, a, b)
//   slave  : multiplier side (drives product, busy, done)
//   start        request, accepted only when busy=0
//   abort        cancel the in-flight operation
//   signed_mode  1: a, b, product are two's complement
//   a, b         multiplicand / multiplier, WIDTH bits
//   product      2*WIDTH-bit result, valid while done=1, held until next accept
//   busy         operation in progress
//   done         one-cycle result-valid pulse
interface seq_mul_param_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 abort;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;
   logic                 done;

   modport master (
      output start, abort, signed_mode, a, b,
      input  product, busy, done
   );

   modport slave (
      input  start, abort, signed_mode, a, b,
      output product, busy, done
   );
endinterface

// File: rtl/seq_mul_param.sv
// seq_mul_param
//   Iterative shift-add multiplier retiring one multiplier bit per clock.
//   Unsigned or two's-complement operation chosen per request (signed_mode,
//   honoured only when SIGNED_EN=1). Fixed latency: done pulses WIDTH+1 edges
//   after the accept edge.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  seq_mul_param_if.slave: start/abort/signed_mode/a/b in,
//        product/busy/done out
module seq_mul_param #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   seq_mul_param_if.slave bus
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   state_t state;
   state_t state_nx;

   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplr;
   logic [CW-1:0]    cnt;
   logic             neg;
   logic [PW-1:0]    product_r;
   logic             busy_r;
   logic             done_r;

   logic             accept;
   logic             step;
   logic             finish;
   logic             cancel;
   logic             sgn;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   // Magnitudes fit WIDTH unsigned bits even for -2^(WIDTH-1), so the
   // unsigned iteration stays exact for every signed operand pair.
   always_comb begin
      sgn   = bus.signed_mode & SIGNED_EN;
      mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Abort takes priority over both a new request in IDLE and the result
   // write in FINISH.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      cancel   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               cancel   = 1'b1;
               state_nx = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CW'(1)) begin
                  state_nx = FINISH;
               end
            end
         end
         FINISH: begin
            state_nx = IDLE;
            if (bus.abort) begin
               cancel = 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         mcand     <= '0;
         mplr      <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         product_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            acc       <= '0;
            mcand     <= PW'(mag_a);
            mplr      <= mag_b;
            cnt       <= CW'(WIDTH);
            neg       <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            product_r <= '0;
            busy_r    <= 1'b1;
         end
         if (step) begin
            if (mplr[0]) begin
               acc <= acc + mcand;
            end
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CW'(1);
         end
         if (finish) begin
            product_r <= neg ? -acc : acc;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
         end
         if (cancel) begin
            product_r <= '0;
            busy_r    <= 1'b0;
         end
      end
   end

   assign bus.product = product_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;

endmodule

// File: tb/tb_seq_mul_param.sv
// tb_seq_mul_param
//   Drives two multipliers (SIGNED_EN=1 and SIGNED_EN=0) with identical
//   stimulus; expected products are queued at request time and compared
//   when each instance pulses done.
module tb_seq_mul_param;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_mul_param_if #(.WIDTH(W)) bus_s ();
   seq_mul_param_if #(.WIDTH(W)) bus_u ();

   seq_mul_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   seq_mul_param #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
      .clk (clk),
      .rst (rst),
      .bus (bus_u)
   );

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] q_s[$];
   logic [2*W-1:0] q_u[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sm, input bit sen);
      int pa;
      int pb;
      if (sm && sen) begin
         pa = int'($signed(a));
         pb = int'($signed(b));
      end else begin
         pa = int'(a);
         pb = int'(b);
      end
      return (2*W)'(pa * pb);
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus_s.done) begin
            if (q_s.size() == 0) check("done_s_unexpected", 32'(bus_s.done), 32'd0);
            else check("prod_s", 32'(bus_s.product), 32'(q_s.pop_front()));
         end
         if (bus_u.done) begin
            if (q_u.size() == 0) check("done_u_unexpected", 32'(bus_u.done), 32'd0);
            else check("prod_u", 32'(bus_u.product), 32'(q_u.pop_front()));
         end
      end
   end

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic st, input logic ab);
      bus_s.a = a;  bus_s.b = b;  bus_s.signed_mode = sm;  bus_s.start = st;  bus_s.abort = ab;
      bus_u.a = a;  bus_u.b = b;  bus_u.signed_mode = sm;  bus_u.start = st;  bus_u.abort = ab;
   endtask

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
      q_s.push_back(ref_mul(a, b, sm, 1'b1));
      q_u.push_back(ref_mul(a, b, sm, 1'b0));
   endtask

   // Called at posedge+1; returns number of edges until done is seen.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (bus_s.done) begin
            lat = i;
            check("done_u_sync", 32'(bus_u.done), 32'd1);
            check("busy_at_done", 32'(bus_s.busy), 32'd0);
            return;
         end
         check("busy_running", 32'(bus_s.busy), 32'd1);
      end
      check("done_timeout", 32'(bus_s.done), 32'd1);
   endtask

   // Issue one operation, scramble inputs after accept, wait for the result.
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                     output int lat);
      drive(a, b, sm, 1'b1, 1'b0);
      push_exp(a, b, sm);
      @(posedge clk);
      #1;
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
      check("busy_after_accept", 32'(bus_s.busy), 32'd1);
      wait_done(lat);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int lat2;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] corner[5];
      corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
      corner[3] = 8'h80; corner[4] = 8'hFF;

      rst = 1'b1;
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_product", 32'(bus_s.product), 32'd0);
      check("rst_busy", 32'(bus_s.busy), 32'd0);
      check("rst_done", 32'(bus_s.done), 32'd0);
      check("rst_busy_u", 32'(bus_u.busy), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // unsigned full-scale
      op(8'd255, 8'd255, 1'b0, lat);
      check("lat_ff_ff", 32'(lat), 32'd9);
      check("prod_ff_ff", 32'(bus_s.product), 32'hFE01);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(bus_s.done), 32'd0);
      check("prod_held", 32'(bus_s.product), 32'hFE01);

      // signed cases; SIGNED_EN=0 instance yields unsigned product
      op(8'hFD, 8'h07, 1'b1, lat);
      check("prod_m3x7", 32'(bus_s.product), 32'hFFEB);
      check("prod_u_fd07", 32'(bus_u.product), 32'h06EB);
      op(8'h80, 8'h80, 1'b1, lat);
      check("prod_m128sq", 32'(bus_s.product), 32'h4000);
      op(8'h00, 8'hFF, 1'b1, lat);
      check("prod_0xm1", 32'(bus_s.product), 32'h0000);
      check("lat_signed", 32'(lat), 32'd9);

      // start held high; inputs changed while busy; second accept on done cycle
      drive(8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
      push_exp(8'd3, 8'd5, 1'b0);
      @(posedge clk);
      #1;
      drive(8'd6, 8'd7, 1'b0, 1'b1, 1'b0);
      push_exp(8'd6, 8'd7, 1'b0);
      wait_done(lat);
      check("b2b_first_lat", 32'(lat), 32'd9);
      check("b2b_first_prod", 32'(bus_s.product), 32'd15);
      wait_done(lat2);
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      check("b2b_spacing", 32'(lat2), 32'(W + 2));
      check("b2b_second_prod", 32'(bus_s.product), 32'd42);

      // abort during the 4th RUN cycle
      @(posedge clk);
      #1;
      drive(8'd10, 8'd12, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      drive(8'd10, 8'd12, 1'b0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("abort_pre_busy", 32'(bus_s.busy), 32'd1);
      drive(8'd10, 8'd12, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(8'd10, 8'd12, 1'b0, 1'b0, 1'b0);
      check("abort_busy", 32'(bus_s.busy), 32'd0);
      check("abort_done", 32'(bus_s.done), 32'd0);
      check("abort_product", 32'(bus_s.product), 32'd0);
      check("abort_busy_u", 32'(bus_u.busy), 32'd0);
      repeat (12) begin
         @(posedge clk);
         #1;
         check("abort_no_done", 32'(bus_s.done), 32'd0);
      end
      // abort and start together in IDLE: start ignored
      drive(8'd10, 8'd12, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      drive(8'd10, 8'd12, 1'b0, 1'b0, 1'b0);
      check("abort_beats_start", 32'(bus_s.busy), 32'd0);
      op(8'd10, 8'd12, 1'b0, lat);
      check("after_abort_prod", 32'(bus_s.product), 32'd120);

      // asynchronous reset mid-RUN
      @(posedge clk);
      #1;
      drive(8'h55, 8'h33, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      drive(8'h55, 8'h33, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus_s.busy), 32'd0);
      check("arst_done", 32'(bus_s.done), 32'd0);
      check("arst_product", 32'(bus_s.product), 32'd0);
      check("arst_busy_u", 32'(bus_u.busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_stays_idle", 32'(bus_s.busy), 32'd0);

      // random sweep with corner operands mixed in
      for (int n = 0; n < 1000; n++) begin
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
         op(ra, rb, 1'($urandom_range(0, 1)), lat);
         check("sweep_lat", 32'(lat), 32'd9);
      end

      @(posedge clk);
      #1;
      check("queue_s_drained", 32'(q_s.size()), 32'd0);
      check("queue_u_drained", 32'(q_u.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
